// File: rtl/prince_seq_ctrl.sv
// Sequencer around the two-phase PRINCE round datapath: handshake, key expansion,
// whitening and phase/load control. Define PRINCE_DEC_EN to enable the decrypt schedule.
module prince_seq_ctrl #(
    parameter logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic [127:0]  in_key,
    input  logic          in_decrypt,
    output logic [63:0]   core_in,
    output logic [63:0]   core_k1,
    output logic          core_phase,
    output logic          core_load,
    input  logic [63:0]   core_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   data_q, data_d;
    logic [127:0]  key_q, key_d;
    logic [63:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [63:0]   k0, k1, k0_prime, kin, kout;

    assign k0       = key_q[127:64];
    assign k1       = key_q[63:0];
    assign k0_prime = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};

`ifdef PRINCE_DEC_EN
    logic dec_q, dec_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end

    always_comb begin
        dec_d = dec_q;
        if (state_q == IDLE && in_valid) begin
            dec_d = in_decrypt;
        end
    end

    // Decryption swaps the whitening keys and reflects k1 through ALPHA.
    assign kin     = dec_q ? k0_prime : k0;
    assign kout    = dec_q ? k0 : k0_prime;
    assign core_k1 = dec_q ? (k1 ^ ALPHA) : k1;
`else
    logic unused_ok;
    assign unused_ok = ^{in_decrypt, ALPHA};

    assign kin     = k0;
    assign kout    = k0_prime;
    assign core_k1 = k1;
`endif

    assign core_in   = data_q ^ kin;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            key_q       <= key_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        key_d       = key_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        core_phase  = 1'b0;
        core_load   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    key_d   = in_key;
                    state_d = PH0;
                end
            end
            PH0: begin
                core_load = 1'b1;
                state_d   = PH1;
            end
            PH1: begin
                // Output whitening is folded into the result register here.
                core_phase  = 1'b1;
                out_data_d  = core_out ^ kout;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prince_seq_ctrl.sv
// Bench for prince_seq_ctrl: a behavioural two-phase PRINCE datapath model feeds core_out,
// a queue-based scoreboard checks every delivered block against known answers.
module tb_prince_seq_ctrl;

    localparam logic [63:0] ALPHA_C = 64'hC0AC29B7C97C50DD;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [127:0]  in_key;
    logic          in_decrypt;
    logic [63:0]   core_in;
    logic [63:0]   core_k1;
    logic          core_phase;
    logic          core_load;
    logic [63:0]   core_out;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          busy;

    logic [63:0]   mid_q;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    prince_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .core_in    (core_in),
        .core_k1    (core_k1),
        .core_phase (core_phase),
        .core_load  (core_load),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- PRINCE datapath model ----------------
    function automatic logic [63:0] rc(input int r);
        case (r)
            0:       return 64'h0000000000000000;
            1:       return 64'h13198A2E03707344;
            2:       return 64'hA4093822299F31D0;
            3:       return 64'h082EFA98EC4E6C89;
            4:       return 64'h452821E638D01377;
            5:       return 64'hBE5466CF34E90C6C;
            6:       return 64'h7EF84F78FD955CB1;
            7:       return 64'h85840851F1AC43AA;
            8:       return 64'hC882D32F25323C54;
            9:       return 64'h64A51195E0E3610D;
            10:      return 64'hD3B5A399CA0C2399;
            default: return 64'hC0AC29B7C97C50DD;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x, input bit inv);
        logic [63:0] tbl;
        logic [63:0] y;
        int          v;
        tbl = inv ? 64'hB732FD89A6405EC1 : 64'hBF32AC916780E5D4;
        y   = '0;
        for (int n = 0; n < 16; n++) begin
            v = int'(x[4*n +: 4]);
            y[4*n +: 4] = tbl[63 - 4*v -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_prime(input logic [63:0] x);
        logic [63:0] y;
        logic        acc;
        int          excl;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 4; b++) begin
                    excl = (c == 0 || c == 3) ? ((b - j - 1 + 8) % 4) : ((b - j + 8) % 4);
                    acc  = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (i != excl) acc = acc ^ x[16*c + 4*i + b];
                    end
                    y[16*c + 4*j + b] = acc;
                end
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i + 4*(i % 4)) % 16;
            if (!inv) y[63 - 4*i -: 4]   = x[63 - 4*src -: 4];
            else      y[63 - 4*src -: 4] = x[63 - 4*i -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] fwd_half(input logic [63:0] x, input logic [63:0] k1);
        logic [63:0] s;
        s = x ^ k1 ^ rc(0);
        for (int r = 1; r < 6; r++) begin
            s = s_layer(s, 1'b0);
            s = shift_rows(m_prime(s), 1'b0);
            s = s ^ k1 ^ rc(r);
        end
        s = s_layer(s, 1'b0);
        s = m_prime(s);
        s = s_layer(s, 1'b1);
        return s;
    endfunction

    function automatic logic [63:0] inv_half(input logic [63:0] x, input logic [63:0] k1);
        logic [63:0] s;
        s = x;
        for (int r = 6; r < 11; r++) begin
            s = s ^ k1 ^ rc(r);
            s = m_prime(shift_rows(s, 1'b1));
            s = s_layer(s, 1'b1);
        end
        return s ^ k1 ^ rc(11);
    endfunction

    function automatic logic [63:0] kprime(input logic [63:0] k0);
        return {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    endfunction

    always_ff @(posedge clk) begin
        if (core_load) mid_q <= fwd_half(core_in, core_k1);
    end

    assign core_out = inv_half(mid_q, core_k1);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: latency on the rising out_valid, data on each handshake.
    initial begin : monitor
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && !prev_v && exp_q.size() != 0)
                chk("latency", 64'(cyc - exp_q[0].acc), 64'd3);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    $display("[TB] result %h expected %h", out_data, e.data);
                end
            end
            prev_v = (out_valid === 1'b1);
        end
    end

    // Issues one request; returns aligned just after the edge that enters PH1.
    task automatic send(input logic [63:0] d, input logic [127:0] k, input logic dec,
                        input logic [63:0] exp, input bit track);
        int          n;
        exp_t        e;
        logic [63:0] kin_e, k1_e;
        kin_e = k[127:64];
        k1_e  = k[63:0];
`ifdef PRINCE_DEC_EN
        if (dec) begin
            kin_e = kprime(k[127:64]);
            k1_e  = k[63:0] ^ ALPHA_C;
        end
`endif
        n = 0;
        while (in_ready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_data    = d;
        in_key     = k;
        in_decrypt = dec;
        @(negedge clk);
        if (track) begin
            e.data = exp;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        tick();
        in_valid   = 1'b0;
        in_data    = ~d;
        in_key     = ~k;
        in_decrypt = ~dec;
        @(negedge clk);
        chk("in_ready_drop", 64'(in_ready), 64'd0);
        chk("ph0_load", 64'({core_load, core_phase}), 64'd2);
        chk("core_in", core_in, d ^ kin_e);
        chk("core_k1", core_k1, k1_e);
        tick();
        $display("[TB] issued data %h key %h dec %0d", d, k, dec);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wait_done: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_phase_load", 64'({core_phase, core_load}), 64'd0);
        chk("rst_core_in", core_in, 64'd0);
        chk("rst_core_k1", core_k1, 64'd0);
        tick();

        send(64'h0, 128'h0, 1'b0, 64'h818665AA0D02DFDA, 1'b1);
        wait_done();
        send(64'hFFFFFFFFFFFFFFFF, 128'h0, 1'b0, 64'h604AE6CA03C20ADA, 1'b1);
        wait_done();
        send(64'h0, {64'hFFFFFFFFFFFFFFFF, 64'h0}, 1'b0, 64'h9FB51935FC3DF524, 1'b1);
        wait_done();
        send(64'h0123456789ABCDEF, {64'h0, 64'hFEDCBA9876543210}, 1'b0, 64'hAE25AD3CA8FA9CCF, 1'b1);
        wait_done();
`ifdef PRINCE_DEC_EN
        send(64'hAE25AD3CA8FA9CCF, {64'h0, 64'hFEDCBA9876543210}, 1'b1, 64'h0123456789ABCDEF, 1'b1);
`else
        send(64'h0, 128'h0, 1'b1, 64'h818665AA0D02DFDA, 1'b1);
`endif
        wait_done();

        // Backpressure: result must sit unchanged until the consumer takes it.
        out_ready = 1'b0;
        send(64'h0, {64'hFFFFFFFFFFFFFFFF, 64'h0}, 1'b0, 64'h9FB51935FC3DF524, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 16);
        chk("bp_valid_wait", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, 64'h9FB51935FC3DF524);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_release_idle", 64'({in_ready, out_valid, busy}), 64'b100);
        tick();

        // Reset in PH1: the in-flight block must vanish without a trace.
        send(64'h0123456789ABCDEF, {64'h0, 64'hFEDCBA9876543210}, 1'b0, 64'h0, 1'b0);
        chk("ph1_phase", 64'({core_phase, core_load}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_data", out_data, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        tick();
        send(64'hFFFFFFFFFFFFFFFF, 128'h0, 1'b0, 64'h604AE6CA03C20ADA, 1'b1);
        wait_done();

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
